// File: rtl/game_vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz) and a sync-window helper
// used by the game_vga_timing display path.
`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 3
`endif

package game_vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam int V_SYNC_START = V_ACTIVE + V_FRONT;

  // True when pos lies in the half-open window [start, start+len).
  function automatic logic in_window(input int pos, input int start, input int len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage

// File: rtl/game_pixel_strobe.sv
// Modulo-DIV counter producing a one-clock pixel strobe; the strobe marks the
// clock edge on which the scan advances.
module game_pixel_strobe #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic strobe
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // With DIV = 1 this is permanently high, so the scan advances every clock.
  assign strobe = (cnt_q == LAST);

endmodule

// File: rtl/game_vga_timing.sv
// VGA scan generator: pixel strobe, scan counters, game-facing coordinates and
// a second stage that blanks rgb_in and aligns it with hsync/vsync.
module game_vga_timing
  import game_vga_pkg::*;
#(
  parameter int CLK_MHZ   = 50,
  parameter int PIXEL_MHZ = 25,
  parameter int H_ACTIVE  = game_vga_pkg::H_ACTIVE,
  parameter int H_FRONT   = game_vga_pkg::H_FRONT,
  parameter int H_SYNC    = game_vga_pkg::H_SYNC,
  parameter int H_BACK    = game_vga_pkg::H_BACK,
  parameter int V_ACTIVE  = game_vga_pkg::V_ACTIVE,
  parameter int V_FRONT   = game_vga_pkg::V_FRONT,
  parameter int V_SYNC    = game_vga_pkg::V_SYNC,
  parameter int V_BACK    = game_vga_pkg::V_BACK,
  parameter int SYNC_NEG  = 1,
  parameter int RGB_WIDTH = `GAME_RGB_WIDTH,
  parameter int w_x       = $clog2(H_ACTIVE),
  parameter int w_y       = $clog2(V_ACTIVE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 pixel_strobe,
  output logic                 display_on,
  output logic [w_x-1:0]       x,
  output logic [w_y-1:0]       y,
  output logic                 frame_start,
  input  logic [RGB_WIDTH-1:0] rgb_in,
  output logic [RGB_WIDTH-1:0] vga_rgb,
  output logic                 hsync,
  output logic                 vsync
);

  localparam int DIV          = CLK_MHZ / PIXEL_MHZ;
  localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
  localparam int HW           = $clog2(H_TOTAL);
  localparam int VW           = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_W = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_W = VW'(V_ACTIVE);
  localparam logic          SYNC_INACTIVE = (SYNC_NEG != 0);

  logic strobe;

  game_pixel_strobe #(.DIV(DIV)) u_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (strobe)
  );

  logic [HW-1:0]        h_q, h_d;
  logic [VW-1:0]        v_q, v_d;
  logic                 pixel_strobe_q, pixel_strobe_d;
  logic                 display_on_q, display_on_d;
  logic [w_x-1:0]       x_q, x_d;
  logic [w_y-1:0]       y_q, y_d;
  logic                 hs_raw_q, hs_raw_d;
  logic                 vs_raw_q, vs_raw_d;
  logic                 frame_start_q, frame_start_d;
  logic [RGB_WIDTH-1:0] vga_rgb_q, vga_rgb_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 active;

  // Counters start on the last position so the first strobe lands on (0,0).
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (strobe) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    active         = (h_d < H_ACT_W) && (v_d < V_ACT_W);
    pixel_strobe_d = strobe;
    frame_start_d  = 1'b0;
    display_on_d   = display_on_q;
    x_d            = x_q;
    y_d            = y_q;
    hs_raw_d       = hs_raw_q;
    vs_raw_d       = vs_raw_q;
    vga_rgb_d      = vga_rgb_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    if (strobe) begin
      display_on_d  = active;
      x_d           = active ? h_d[w_x-1:0] : '0;
      y_d           = active ? v_d[w_y-1:0] : '0;
      hs_raw_d      = in_window(int'(h_d), H_SYNC_START, H_SYNC);
      vs_raw_d      = in_window(int'(v_d), V_SYNC_START, V_SYNC);
      frame_start_d = (h_d == '0) && (v_d == '0);
      // Stage 2 consumes the previous stage-1 values, one pixel behind x/y.
      vga_rgb_d     = display_on_q ? rgb_in : '0;
      hsync_d       = hs_raw_q ^ SYNC_INACTIVE;
      vsync_d       = vs_raw_q ^ SYNC_INACTIVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q            <= H_LAST;
      v_q            <= V_LAST;
      pixel_strobe_q <= 1'b0;
      display_on_q   <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      hs_raw_q       <= 1'b0;
      vs_raw_q       <= 1'b0;
      frame_start_q  <= 1'b0;
      vga_rgb_q      <= '0;
      hsync_q        <= SYNC_INACTIVE;
      vsync_q        <= SYNC_INACTIVE;
    end else begin
      h_q            <= h_d;
      v_q            <= v_d;
      pixel_strobe_q <= pixel_strobe_d;
      display_on_q   <= display_on_d;
      x_q            <= x_d;
      y_q            <= y_d;
      hs_raw_q       <= hs_raw_d;
      vs_raw_q       <= vs_raw_d;
      frame_start_q  <= frame_start_d;
      vga_rgb_q      <= vga_rgb_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
    end
  end

  assign pixel_strobe = pixel_strobe_q;
  assign display_on   = display_on_q;
  assign x            = x_q;
  assign y            = y_q;
  assign frame_start  = frame_start_q;
  assign vga_rgb      = vga_rgb_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;

endmodule

// File: tb/tb_game_vga_timing.sv
// Bench for game_vga_timing: three instances (default DIV=2, small-geometry
// DIV=2, default DIV=1) checked every clock against a pixel-index model.
module tb_game_vga_timing;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } geom_t;

  typedef struct {
    int strobe, disp, fs, x, y, rgb, hs, vs;
  } exp_t;

  geom_t geom_def   = '{640, 16, 96, 48, 480, 10, 2, 33};
  geom_t geom_small = '{16, 2, 3, 4, 8, 2, 2, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n = 1'b0, rst_b_n = 1'b0, rst_c_n = 1'b0;
  logic [2:0] rgb_a = 3'd0, rgb_b = 3'd0, rgb_c = 3'd0;

  logic       ps_a, disp_a, fs_a, hsync_a, vsync_a;
  logic [9:0] x_a;
  logic [8:0] y_a;
  logic [2:0] vga_a;

  logic       ps_b, disp_b, fs_b, hsync_b, vsync_b;
  logic [3:0] x_b;
  logic [2:0] y_b;
  logic [2:0] vga_b;

  logic       ps_c, disp_c, fs_c, hsync_c, vsync_c;
  logic [9:0] x_c;
  logic [8:0] y_c;
  logic [2:0] vga_c;

  game_vga_timing #(.CLK_MHZ(50), .PIXEL_MHZ(25), .RGB_WIDTH(3)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .pixel_strobe(ps_a), .display_on(disp_a),
    .x(x_a), .y(y_a), .frame_start(fs_a), .rgb_in(rgb_a), .vga_rgb(vga_a),
    .hsync(hsync_a), .vsync(vsync_a)
  );

  game_vga_timing #(
    .CLK_MHZ(50), .PIXEL_MHZ(25),
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .RGB_WIDTH(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .pixel_strobe(ps_b), .display_on(disp_b),
    .x(x_b), .y(y_b), .frame_start(fs_b), .rgb_in(rgb_b), .vga_rgb(vga_b),
    .hsync(hsync_b), .vsync(vsync_b)
  );

  game_vga_timing #(.CLK_MHZ(25), .PIXEL_MHZ(25), .RGB_WIDTH(3)) dut_c (
    .clk(clk), .rst_n(rst_c_n), .pixel_strobe(ps_c), .display_on(disp_c),
    .x(x_c), .y(y_c), .frame_start(fs_c), .rgb_in(rgb_c), .vga_rgb(vga_c),
    .hsync(hsync_c), .vsync(vsync_c)
  );

  int checks = 0;
  int failures = 0;
  int ka = 0, kb = 0, kc = 0;
  int last_a = 0, last_b = 0, last_c = 0;
  int disp_cnt_a = 0, hlow_cnt_a = 0, first_hlow_a = -1;
  int fs_prev_b = 0;
  int rise_prev_c = 0;
  logic disp_prev_c = 1'b0;

  // Expected outputs after k clock edges since reset release, from the pixel index.
  function automatic exp_t model(input int k, input int div, input geom_t g, input int rgb_last);
    exp_t e;
    int ht, vt, p, h, v, q, hq, vq;
    e = '{strobe: 0, disp: 0, fs: 0, x: 0, y: 0, rgb: 0, hs: 1, vs: 1};
    if (k < div) return e;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    p = k / div - 1;
    h = p % ht;
    v = (p / ht) % vt;
    e.strobe = (k % div == 0) ? 1 : 0;
    e.disp   = (h < g.ha && v < g.va) ? 1 : 0;
    e.x      = (e.disp != 0) ? h : 0;
    e.y      = (e.disp != 0) ? v : 0;
    e.fs     = (e.strobe != 0 && (p % (ht * vt)) == 0) ? 1 : 0;
    if (p > 0) begin
      q  = p - 1;
      hq = q % ht;
      vq = (q / ht) % vt;
      e.rgb = (hq < g.ha && vq < g.va) ? rgb_last : 0;
      e.hs  = (hq >= g.ha + g.hf && hq < g.ha + g.hf + g.hs) ? 0 : 1;
      e.vs  = (vq >= g.va + g.vf && vq < g.va + g.vf + g.vs) ? 0 : 1;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic checkDut(input string name, input int k, input int div, input geom_t g,
                          input int rgb_last, input logic ps, input logic disp, input logic fs,
                          input logic hs, input logic vs, input logic [31:0] xv,
                          input logic [31:0] yv, input logic [31:0] rgbv);
    exp_t e;
    e = model(k, div, g, rgb_last);
    checkOutput({name, ".pixel_strobe"}, k, 32'(ps), e.strobe);
    checkOutput({name, ".display_on"}, k, 32'(disp), e.disp);
    checkOutput({name, ".frame_start"}, k, 32'(fs), e.fs);
    checkOutput({name, ".x"}, k, xv, e.x);
    checkOutput({name, ".y"}, k, yv, e.y);
    checkOutput({name, ".vga_rgb"}, k, rgbv, e.rgb);
    checkOutput({name, ".hsync"}, k, 32'(hs), e.hs);
    checkOutput({name, ".vsync"}, k, 32'(vs), e.vs);
  endtask

  task automatic checkAll();
    checkDut("a", ka, 2, geom_def, last_a, ps_a, disp_a, fs_a, hsync_a, vsync_a,
             32'(x_a), 32'(y_a), 32'(vga_a));
    checkDut("b", kb, 2, geom_small, last_b, ps_b, disp_b, fs_b, hsync_b, vsync_b,
             32'(x_b), 32'(y_b), 32'(vga_b));
    checkDut("c", kc, 1, geom_def, last_c, ps_c, disp_c, fs_c, hsync_c, vsync_c,
             32'(x_c), 32'(y_c), 32'(vga_c));
  endtask

  // One clock: note edge count and rgb at strobe edges, check on the falling edge, then new colours.
  task automatic applyStimulus();
    int pa;
    @(posedge clk);
    if (rst_a_n) ka++;
    if (rst_b_n) kb++;
    if (rst_c_n) kc++;
    if (rst_a_n && ka % 2 == 0) last_a = int'(rgb_a);
    if (rst_b_n && kb % 2 == 0) last_b = int'(rgb_b);
    if (rst_c_n) last_c = int'(rgb_c);
    @(negedge clk);
    checkAll();
    if (ka >= 2 && ka % 2 == 0) begin
      pa = ka / 2 - 1;
      if (pa < 800 && disp_a) disp_cnt_a++;
      if (pa >= 1 && pa <= 800 && !hsync_a) begin
        hlow_cnt_a++;
        if (first_hlow_a < 0) first_hlow_a = pa;
      end
    end
    if (fs_b) begin
      if (fs_prev_b > 0) checkOutput("b.frame_period", kb, kb - fs_prev_b, 750);
      fs_prev_b = kb;
    end
    if (disp_c && !disp_prev_c) begin
      if (rise_prev_c > 0) checkOutput("c.line_clocks", kc, kc - rise_prev_c, 800);
      rise_prev_c = kc;
    end
    disp_prev_c = disp_c;
    rgb_a = 3'($urandom_range(0, 7));
    rgb_b = 3'($urandom_range(0, 7));
    rgb_c = 3'($urandom_range(0, 7));
  endtask

  initial begin
    logic found;
    $display("[TB] start");
    repeat (3) begin
      @(negedge clk);
      checkAll();
    end
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    rst_c_n = 1'b1;

    repeat (2600) applyStimulus();
    checkOutput("a.display_strobes_per_line", ka, disp_cnt_a, 640);
    checkOutput("a.hsync_low_strobes", ka, hlow_cnt_a, 96);
    checkOutput("a.hsync_first_low_pixel", ka, first_hlow_a, 657);

    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      applyStimulus();
      found = (kb % 2 == 0) && (((kb / 2 - 1) % 375) == 135);
    end
    checkOutput("b.reached_h10_v5", kb, 32'(found), 1);
    checkOutput("b.x_before_reset", kb, 32'(x_b), 10);
    checkOutput("b.y_before_reset", kb, 32'(y_b), 5);

    rst_b_n = 1'b0;
    kb = 0;
    fs_prev_b = 0;
    #1;
    checkDut("b_async", kb, 2, geom_small, last_b, ps_b, disp_b, fs_b, hsync_b, vsync_b,
             32'(x_b), 32'(y_b), 32'(vga_b));
    repeat (3) applyStimulus();
    rst_b_n = 1'b1;

    repeat (1000) applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
